// File: rtl/commit_unit_if.sv
// rtl/commit_unit_if.sv - ROB head, register file, store, and PC redirect signals of the commit stage
interface commit_unit_if #(
  parameter int W = 16,
  parameter int N = 3
);
  logic         rob_empty;
  logic         rob_valid;
  logic         rob_busy;
  logic [1:0]   rob_type;
  logic [W-1:0] rob_value;
  logic [W-1:0] rob_addr;
  logic [2:0]   rob_dest;
  logic         rob_mispredict;
  logic [N-1:0] rob_head;
  logic         rob_re;
  logic         flush;
  logic         rf_we;
  logic [2:0]   rf_dest;
  logic [W-1:0] rf_value;
  logic         rs_clear;
  logic [N-1:0] rs_tag;
  logic         mem_write;
  logic [W-1:0] mem_address;
  logic [W-1:0] mem_wdata;
  logic         mem_resp;
  logic         pc_load;
  logic [W-1:0] pc_target;
  logic         halted;
  logic [15:0]  commit_count;

  modport master (
    input  rob_empty, rob_valid, rob_busy, rob_type, rob_value, rob_addr,
           rob_dest, rob_mispredict, rob_head, mem_resp,
    output rob_re, flush, rf_we, rf_dest, rf_value, rs_clear, rs_tag,
           mem_write, mem_address, mem_wdata, pc_load, pc_target, halted,
           commit_count
  );

  modport slave (
    output rob_empty, rob_valid, rob_busy, rob_type, rob_value, rob_addr,
           rob_dest, rob_mispredict, rob_head, mem_resp,
    input  rob_re, flush, rf_we, rf_dest, rf_value, rs_clear, rs_tag,
           mem_write, mem_address, mem_wdata, pc_load, pc_target, halted,
           commit_count
  );
endinterface

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order retirement of the ROB head: register write, store handshake, branch resolve
module commit_unit #(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          reset,
  commit_unit_if.master bus
);
  typedef enum logic [1:0] {CHECK, STORE_WAIT, FLUSH, HALTED} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] addr_q, data_q;
  logic [15:0]  count_q;
  logic         head_ready;
  logic         latch_store;

  logic         rob_re_c, flush_c, rf_we_c, mem_write_c, pc_load_c, halted_c;
  logic [2:0]   rf_dest_c;
  logic [W-1:0] rf_value_c, pc_target_c;

  assign head_ready = ~bus.rob_empty & bus.rob_valid & ~bus.rob_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CHECK;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_store) begin
        addr_q <= bus.rob_addr;
        data_q <= bus.rob_value;
      end
      if (rob_re_c || flush_c)
        count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    latch_store = 1'b0;
    rob_re_c    = 1'b0;
    flush_c     = 1'b0;
    rf_we_c     = 1'b0;
    rf_dest_c   = '0;
    rf_value_c  = '0;
    mem_write_c = 1'b0;
    pc_load_c   = 1'b0;
    pc_target_c = '0;
    halted_c    = 1'b0;
    case (state_q)
      CHECK: begin
        if (head_ready) begin
          case (bus.rob_type)
            2'b00: begin
              rf_we_c    = 1'b1;
              rf_dest_c  = bus.rob_dest;
              rf_value_c = bus.rob_value;
              rob_re_c   = 1'b1;
            end
            2'b01: begin
              latch_store = 1'b1;
              state_d     = STORE_WAIT;
            end
            2'b10: begin
              // A mispredict leaves the entry in place; the flush empties the ROB.
              if (bus.rob_mispredict) begin
                flush_c     = 1'b1;
                pc_load_c   = 1'b1;
                pc_target_c = bus.rob_addr;
                state_d     = FLUSH;
              end else begin
                rob_re_c = 1'b1;
              end
            end
            default: begin
              rob_re_c = 1'b1;
              state_d  = HALTED;
            end
          endcase
        end
      end
      STORE_WAIT: begin
        mem_write_c = 1'b1;
        if (bus.mem_resp) begin
          rob_re_c = 1'b1;
          state_d  = CHECK;
        end
      end
      FLUSH: state_d = CHECK;
      default: halted_c = 1'b1;
    endcase
  end

  assign bus.rob_re       = rob_re_c;
  assign bus.flush        = flush_c;
  assign bus.rf_we        = rf_we_c;
  assign bus.rf_dest      = rf_dest_c;
  assign bus.rf_value     = rf_value_c;
  assign bus.rs_clear     = rf_we_c;
  assign bus.rs_tag       = bus.rob_head;
  assign bus.mem_write    = mem_write_c;
  // Latched store fields are only presented while the request is live.
  assign bus.mem_address  = mem_write_c ? addr_q : '0;
  assign bus.mem_wdata    = mem_write_c ? data_q : '0;
  assign bus.pc_load      = pc_load_c;
  assign bus.pc_target    = pc_target_c;
  assign bus.halted       = halted_c;
  assign bus.commit_count = count_q;
endmodule
